spark_ramp_ctrl: RTL
====================

# spark_ramp_ctrl

Slew-rate limiter and update sequencer that sits directly upstream of the SparkMax PWM generator. It accepts a signed speed target (direction + 8-bit magnitude) from the register/control layer. It walks the commanded value toward that target in bounded steps at a fixed tick rate, passing through zero on reversals. It drives the generator's enable/ratio/direction/update inputs and consumes its done pulse, and it performs a commanded stop-to-zero before dropping enable.

## Interface
- RAMP_TICKS, 50000: clocks between ramp steps (≥2).
- DONE_TIMEOUT, 8192: clocks to wait for pwm_done before faulting (≥ 2× generator period of 4096).
- reset_n  in  1  reset, asynchronous, active-low
- clock  in  1  clock
- enable  in  1  motor run request (level)
- target_valid  in  1  one-cycle strobe; latch target_dir/target_mag
- target_dir  in  1  1 = forward, 0 = reverse
- target_mag  in  8  target magnitude 0–255
- ramp_step  in  4  magnitude change per step; 0 treated as 1
- pwm_enable  out  1  to generator
- pwm_ratio  out  8  to generator; current magnitude
- pwm_direction  out  1  to generator; current direction
- pwm_update  out  1  to generator; held high until pwm_done
- pwm_done  in  1  from generator; one-cycle pulse
- at_target  out  1  current == latched target, running, idle between steps
- fault  out  1  sticky done-timeout flag; cleared by enable low
- Reset values: all outputs 0; internal cur/target magnitude 0, direction 0.

## Operation
- FSM states: IDLE, TICK_WAIT, STEP, REQ, STOP_REQ.
- IDLE: pwm_enable=0. enable=1 → pwm_enable=1, go to TICK_WAIT.
- TICK_WAIT: the tick counter counts 0..RAMP_TICKS-1. At terminal count, go to STEP if cur ≠ target; otherwise stay, with at_target=1.
- STEP (1 cycle): compute next value with s = max(ramp_step,1).
  - Directions equal, or cur_mag=0: set cur_dir=tgt_dir, then move cur_mag toward tgt_mag by min(s,|diff|).
  - Directions differ and cur_mag>0: cur_mag -= min(s,cur_mag); direction is unchanged. This means zero is always emitted before the direction flips.
  - Register the result onto pwm_ratio/pwm_direction, then go to REQ.
- REQ: pwm_update=1.
  - On pwm_done: drop pwm_update the next cycle, clear the tick counter, go to TICK_WAIT.
  - If the timeout counter reaches DONE_TIMEOUT-1: set fault=1, drop update, go to TICK_WAIT. The step is retried on the next tick.
- enable=0 in any non-IDLE state: abandon the current step. Drive pwm_ratio=0, keep pwm_direction, assert pwm_update, go to STOP_REQ.
- STOP_REQ: on pwm_done or timeout, set pwm_update=0, pwm_enable=0, cur_mag=0, fault=0, go to IDLE. enable re-asserted here is ignored until IDLE.
- target_valid: accepted in any state. If it coincides with STEP, the STEP uses the old target and the new one applies at the next tick. A later strobe overwrites an earlier one.
- Arithmetic: 9-bit unsigned diff; saturating, never overshoots or wraps below 0 / above 255.

## Timing
- target_valid → first pwm_update rise: ≤ RAMP_TICKS+2 cycles.
- STEP → pwm_update high: 1 cycle. pwm_ratio/pwm_direction are stable from update rise until done.
- pwm_done → pwm_update low: 1 cycle. A pwm_done arriving outside REQ/STOP_REQ is ignored.
- Full-scale ramp 0→255 at step 15: 17 steps.
- Reset mid-operation: all outputs return to 0 immediately (async). A pending request is discarded.

## Structure
- Package spark_ramp_pkg holds:
  - state encoding (enum-style localparams);
  - the PWM_MAG_W=8 and STEP_W=4 widths;
  - the DIR_FWD/DIR_REV constants.
- Sub-module spark_ramp_step: combinational next-value calculator.
  - Inputs: cur_dir, cur_mag, tgt_dir, tgt_mag, step.
  - Outputs: nxt_dir, nxt_mag.
  - Unit-testable in isolation.
- Top level holds the FSM, the tick and timeout counters, and the target latch.

## Test plan
- RAMP_TICKS=4, step 5, target fwd 20 from 0 → pwm_ratio sequence 5,10,15,20, dir 1. Each value is accompanied by a single update/done handshake, then at_target=1.
- cur fwd 10, target rev 10, step 4 → ratio sequence 6,2,0 with dir=1, then 4,8,10 with dir=0. No direction change while ratio>0.
- Generator model withholds pwm_done → fault=1 after DONE_TIMEOUT cycles, pwm_update drops, and the step is retried on the next tick. Restoring done completes the ramp.
- enable low at cur fwd 100 → update issued with ratio 0, then pwm_enable=0 one cycle after done, fault cleared, FSM in IDLE.
- target_valid (rev 50) asserted in the STEP cycle → current step uses the old target, and subsequent steps head to rev 50.
- reset_n asserted during REQ → pwm_update, pwm_enable, pwm_ratio, and fault are all 0 in the same cycle. After release, the block stays idle until enable.

Source files
------------

// File: rtl/spark_ramp_pkg.sv
// Shared widths, direction constants and FSM encoding for the spark ramp controller.
package spark_ramp_pkg;

  localparam int PWM_MAG_W = 8;
  localparam int STEP_W    = 4;

  localparam logic DIR_FWD = 1'b1;
  localparam logic DIR_REV = 1'b0;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_TICK_WAIT = 3'd1,
    ST_STEP      = 3'd2,
    ST_REQ       = 3'd3,
    ST_STOP_REQ  = 3'd4
  } state_t;

endpackage

// File: rtl/spark_ramp_step.sv
// Combinational next-value calculator: one bounded slew step toward the target.
// A reversal first walks the magnitude down to zero before the direction may flip.
module spark_ramp_step
  import spark_ramp_pkg::*;
(
  input  logic                 cur_dir,
  input  logic [PWM_MAG_W-1:0] cur_mag,
  input  logic                 tgt_dir,
  input  logic [PWM_MAG_W-1:0] tgt_mag,
  input  logic [STEP_W-1:0]    step,
  output logic                 nxt_dir,
  output logic [PWM_MAG_W-1:0] nxt_mag
);

  logic [PWM_MAG_W:0]   s_eff;
  logic [PWM_MAG_W:0]   diff;
  logic [PWM_MAG_W-1:0] delta;

  always_comb begin
    s_eff   = (step == '0) ? (PWM_MAG_W+1)'(1) : {{(PWM_MAG_W+1-STEP_W){1'b0}}, step};
    nxt_dir = cur_dir;
    nxt_mag = cur_mag;
    diff    = '0;
    delta   = '0;
    if ((cur_dir != tgt_dir) && (cur_mag != '0)) begin
      diff    = {1'b0, cur_mag};
      delta   = (s_eff < diff) ? s_eff[PWM_MAG_W-1:0] : diff[PWM_MAG_W-1:0];
      nxt_mag = cur_mag - delta;
    end else begin
      nxt_dir = tgt_dir;
      if (tgt_mag >= cur_mag) begin
        diff    = {1'b0, tgt_mag} - {1'b0, cur_mag};
        delta   = (s_eff < diff) ? s_eff[PWM_MAG_W-1:0] : diff[PWM_MAG_W-1:0];
        nxt_mag = cur_mag + delta;
      end else begin
        diff    = {1'b0, cur_mag} - {1'b0, tgt_mag};
        delta   = (s_eff < diff) ? s_eff[PWM_MAG_W-1:0] : diff[PWM_MAG_W-1:0];
        nxt_mag = cur_mag - delta;
      end
    end
  end

endmodule

// File: rtl/spark_ramp_ctrl.sv
// Slew-rate limiter/sequencer feeding the PWM generator; one step per RAMP_TICKS, update held until done.
// Missing done faults after DONE_TIMEOUT and retries next tick; enable low forces a ratio-0 update then disables.
module spark_ramp_ctrl
  import spark_ramp_pkg::*;
#(
  parameter int RAMP_TICKS   = 50000,
  parameter int DONE_TIMEOUT = 8192
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 enable,
  input  logic                 target_valid,
  input  logic                 target_dir,
  input  logic [PWM_MAG_W-1:0] target_mag,
  input  logic [STEP_W-1:0]    ramp_step,
  output logic                 pwm_enable,
  output logic [PWM_MAG_W-1:0] pwm_ratio,
  output logic                 pwm_direction,
  output logic                 pwm_update,
  input  logic                 pwm_done,
  output logic                 at_target,
  output logic                 fault
);

  localparam int TICK_W = (RAMP_TICKS > 2) ? $clog2(RAMP_TICKS) : 1;
  localparam int TO_W   = (DONE_TIMEOUT > 2) ? $clog2(DONE_TIMEOUT) : 1;

  state_t               state, state_nxt;
  logic [TICK_W-1:0]    tick_cnt;
  logic [TO_W-1:0]      to_cnt;
  logic                 cur_dir, tgt_dir, nxt_dir;
  logic [PWM_MAG_W-1:0] cur_mag, tgt_mag, nxt_mag;
  logic                 tick_term, to_term, on_target;
  logic                 do_start, do_step, do_commit, do_timeout, do_stop, do_finish;

  spark_ramp_step u_step (
    .cur_dir (cur_dir),
    .cur_mag (cur_mag),
    .tgt_dir (tgt_dir),
    .tgt_mag (tgt_mag),
    .step    (ramp_step),
    .nxt_dir (nxt_dir),
    .nxt_mag (nxt_mag)
  );

  assign tick_term = (tick_cnt == TICK_W'(RAMP_TICKS - 1));
  assign to_term   = (to_cnt == TO_W'(DONE_TIMEOUT - 1));
  assign on_target = (cur_dir == tgt_dir) && (cur_mag == tgt_mag);
  assign at_target = (state == ST_TICK_WAIT) && on_target;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    do_start   = 1'b0;
    do_step    = 1'b0;
    do_commit  = 1'b0;
    do_timeout = 1'b0;
    do_stop    = 1'b0;
    do_finish  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (enable) begin
          do_start  = 1'b1;
          state_nxt = ST_TICK_WAIT;
        end
      end
      ST_TICK_WAIT: begin
        if (!enable) begin
          do_stop   = 1'b1;
          state_nxt = ST_STOP_REQ;
        end else if (tick_term && !on_target) begin
          state_nxt = ST_STEP;
        end
      end
      ST_STEP: begin
        if (!enable) begin
          do_stop   = 1'b1;
          state_nxt = ST_STOP_REQ;
        end else begin
          do_step   = 1'b1;
          state_nxt = ST_REQ;
        end
      end
      ST_REQ: begin
        if (!enable) begin
          do_stop   = 1'b1;
          state_nxt = ST_STOP_REQ;
        end else if (pwm_done) begin
          do_commit = 1'b1;
          state_nxt = ST_TICK_WAIT;
        end else if (to_term) begin
          do_timeout = 1'b1;
          state_nxt  = ST_TICK_WAIT;
        end
      end
      ST_STOP_REQ: begin
        if (pwm_done || to_term) begin
          do_finish = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Leaving TICK_WAIT always resets the tick phase, so a retry or a new step waits a full period.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      tick_cnt <= '0;
      to_cnt   <= '0;
    end else begin
      if (state != ST_TICK_WAIT || tick_term) tick_cnt <= '0;
      else                                    tick_cnt <= tick_cnt + 1'b1;
      if (do_stop || (state != ST_REQ && state != ST_STOP_REQ)) to_cnt <= '0;
      else                                                      to_cnt <= to_cnt + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      tgt_dir <= DIR_REV;
      tgt_mag <= '0;
    end else if (target_valid) begin
      tgt_dir <= target_dir;
      tgt_mag <= target_mag;
    end
  end

  // cur_* only advances on an acknowledged update, so a timed-out step is recomputed identically.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cur_dir       <= DIR_REV;
      cur_mag       <= '0;
      pwm_enable    <= 1'b0;
      pwm_ratio     <= '0;
      pwm_direction <= DIR_REV;
      pwm_update    <= 1'b0;
      fault         <= 1'b0;
    end else begin
      if (do_start) pwm_enable <= 1'b1;
      if (do_step) begin
        pwm_ratio     <= nxt_mag;
        pwm_direction <= nxt_dir;
        pwm_update    <= 1'b1;
      end
      if (do_commit) begin
        pwm_update <= 1'b0;
        cur_dir    <= pwm_direction;
        cur_mag    <= pwm_ratio;
      end
      if (do_timeout) begin
        pwm_update <= 1'b0;
        fault      <= 1'b1;
      end
      if (do_stop) begin
        pwm_ratio  <= '0;
        pwm_update <= 1'b1;
      end
      if (do_finish) begin
        pwm_update <= 1'b0;
        pwm_enable <= 1'b0;
        cur_mag    <= '0;
        fault      <= 1'b0;
      end
    end
  end

endmodule
